// File: rtl/player_packet_decoder.sv
// Player packet decoder.
// Decodes one-byte player packets from a UART receiver, tracks link health with a
// DOWN/ACQ/UP state machine and presents registered control outputs.
//
// Byte format: [7] remote reset, [6] reserved (must be 0), [5] fire level,
//              [4] projectile type, [3:0] lane code (0..6, code 0 maps to lane 3).
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   rx_data          received byte, valid while rx_valid=1
//   rx_valid         one-cycle strobe marking a new byte
//   lane             decoded lane 1..6 (3 while link is not up)
//   proj_type        selected projectile type (0 while link is not up)
//   fire_pulse       one-cycle pulse per new fire press
//   remote_rst_pulse one-cycle pulse on the first remote-reset byte of a run
//   pkt_strobe       one-cycle pulse per accepted packet while up
//   link_up          high while the link is UP
//   err_count        saturating count of malformed bytes
module player_packet_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned ACQ_PKTS       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] lane,
    output logic       proj_type,
    output logic       fire_pulse,
    output logic       remote_rst_pulse,
    output logic       pkt_strobe,
    output logic       link_up,
    output logic [7:0] err_count
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimeoutVal = TimerW'(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimerOne   = TimerW'(1);
    localparam logic [3:0]        AcqTarget  = 4'(ACQ_PKTS);
    localparam logic [3:0]        LaneIdle   = 4'd3;

    typedef enum logic [1:0] {StDown, StAcq, StUp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        acq_cnt_q, acq_cnt_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        lane_q, lane_d;
    logic              proj_q, proj_d;
    logic              prev_fire_q, prev_fire_d;
    // Set when the next remote-reset byte should produce a pulse.
    logic              rrst_armed_q, rrst_armed_d;
    logic              fire_q, fire_d;
    logic              rrst_q, rrst_d;
    logic              pkt_q, pkt_d;
    logic              link_q, link_d;
    logic [7:0]        err_q, err_d;

    logic       well_formed;
    logic       malformed;
    logic       timeout;
    logic       acquire;
    logic [3:0] lane_dec;

    assign well_formed = rx_valid && !rx_data[6] && (rx_data[3:0] <= 4'd6);
    assign malformed   = rx_valid && !well_formed;
    assign lane_dec    = (rx_data[3:0] == 4'd0) ? LaneIdle : rx_data[3:0];
    // A well-formed byte arriving on the expiry cycle cancels the timeout.
    assign timeout     = (timer_q == TimeoutVal) && !well_formed;

    always_comb begin
        state_d      = state_q;
        acq_cnt_d    = acq_cnt_q;
        lane_d       = lane_q;
        proj_d       = proj_q;
        prev_fire_d  = prev_fire_q;
        rrst_armed_d = rrst_armed_q;
        fire_d       = 1'b0;
        rrst_d       = 1'b0;
        pkt_d        = 1'b0;
        acquire      = 1'b0;

        if (well_formed) begin
            timer_d = '0;
        end else if (timer_q == TimeoutVal) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TimerOne;
        end

        err_d = (malformed && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

        unique case (state_q)
            StDown: begin
                acq_cnt_d = 4'd0;
                if (well_formed) begin
                    if (ACQ_PKTS <= 1) begin
                        acquire = 1'b1;
                    end else begin
                        state_d   = StAcq;
                        acq_cnt_d = 4'd1;
                    end
                end
            end
            StAcq: begin
                if (well_formed) begin
                    if ((acq_cnt_q + 4'd1) >= AcqTarget) begin
                        acquire = 1'b1;
                    end else begin
                        acq_cnt_d = acq_cnt_q + 4'd1;
                    end
                end else if (malformed || timeout) begin
                    state_d   = StDown;
                    acq_cnt_d = 4'd0;
                end
            end
            StUp: begin
                if (well_formed) begin
                    pkt_d = 1'b1;
                    if (rx_data[7]) begin
                        lane_d       = LaneIdle;
                        proj_d       = 1'b0;
                        prev_fire_d  = 1'b1;
                        rrst_d       = rrst_armed_q;
                        rrst_armed_d = 1'b0;
                    end else begin
                        lane_d       = lane_dec;
                        proj_d       = rx_data[4];
                        fire_d       = rx_data[5] && !prev_fire_q;
                        prev_fire_d  = rx_data[5];
                        rrst_armed_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d   = StDown;
                    acq_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d   = StDown;
                acq_cnt_d = 4'd0;
            end
        endcase

        // The completing byte only loads state; it produces no pulses.
        if (acquire) begin
            state_d      = StUp;
            acq_cnt_d    = 4'd0;
            lane_d       = lane_dec;
            proj_d       = rx_data[4];
            prev_fire_d  = rx_data[5];
            rrst_armed_d = 1'b1;
        end

        if (state_d != StUp) begin
            lane_d = LaneIdle;
            proj_d = 1'b0;
        end
        link_d = (state_d == StUp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StDown;
            acq_cnt_q    <= 4'd0;
            timer_q      <= '0;
            lane_q       <= LaneIdle;
            proj_q       <= 1'b0;
            prev_fire_q  <= 1'b0;
            rrst_armed_q <= 1'b1;
            fire_q       <= 1'b0;
            rrst_q       <= 1'b0;
            pkt_q        <= 1'b0;
            link_q       <= 1'b0;
            err_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            acq_cnt_q    <= acq_cnt_d;
            timer_q      <= timer_d;
            lane_q       <= lane_d;
            proj_q       <= proj_d;
            prev_fire_q  <= prev_fire_d;
            rrst_armed_q <= rrst_armed_d;
            fire_q       <= fire_d;
            rrst_q       <= rrst_d;
            pkt_q        <= pkt_d;
            link_q       <= link_d;
            err_q        <= err_d;
        end
    end

    assign lane             = lane_q;
    assign proj_type        = proj_q;
    assign fire_pulse       = fire_q;
    assign remote_rst_pulse = rrst_q;
    assign pkt_strobe       = pkt_q;
    assign link_up          = link_q;
    assign err_count        = err_q;

endmodule

// File: doc/player_packet_decoder.md
PLAYER_PACKET_DECODER -- requirements
Module: player_packet_decoder

Interface
REQ-001 The block SHALL provide the parameter TIMEOUT_CYCLES, default 5000000, the number of clk cycles without an accepted packet before the link drops.
REQ-002 The block SHALL provide the parameter ACQ_PKTS, default 2, range 1..15, the number of consecutive well-formed packets required to bring the link up.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port rx_data, input, 8, the received player byte; it is valid only while rx_valid=1.
REQ-006 The block SHALL have port rx_valid, input, 1, a one-cycle strobe from the UART receiver marking a new byte.
REQ-007 The block SHALL have port lane, output, 4, the decoded player lane, range 1..6.
REQ-008 The block SHALL have port proj_type, output, 1, the currently selected projectile type.
REQ-009 The block SHALL have port fire_pulse, output, 1, a one-cycle pulse per new fire press.
REQ-010 The block SHALL have port remote_rst_pulse, output, 1, a one-cycle pulse when the sender signals reset.
REQ-011 The block SHALL have port pkt_strobe, output, 1, a one-cycle pulse per accepted packet while link_up=1.
REQ-012 The block SHALL have port link_up, output, 1, set while the link state is UP.
REQ-013 The block SHALL have port err_count, output, 8, a saturating count of malformed bytes.

Function
REQ-014 The byte format SHALL be: bit7 = remote reset, bit6 = reserved and must be 0, bit5 = fire level, bit4 = projectile type, bits3:0 = lane code.
REQ-015 A byte SHALL be well-formed iff bit6=0 and the lane code is 0..6; lane code 0 (sender RESET state) SHALL map to lane 3.
REQ-016 A malformed byte SHALL be dropped, SHALL increment err_count (saturating at 255), and SHALL NOT restart the timeout timer.
REQ-017 All outputs SHALL be registered; an accepted byte SHALL affect the outputs on the cycle after its rx_valid (latency 1).
REQ-018 The state machine SHALL have three states: DOWN, ACQ and UP.
REQ-019 DOWN SHALL go to ACQ on a well-formed byte with acq_cnt=1; if ACQ_PKTS=1, it SHALL go directly to UP instead.
REQ-020 In ACQ, a well-formed byte SHALL increment acq_cnt; on reaching ACQ_PKTS the state SHALL go to UP.
REQ-021 In ACQ, a malformed byte or a timeout SHALL send the state to DOWN with acq_cnt=0.
REQ-022 In UP, a timeout SHALL send the state to DOWN.
REQ-023 On the transition into UP, the block SHALL load lane, proj_type and prev_fire from the completing byte, and SHALL NOT emit fire_pulse or pkt_strobe for that byte.
REQ-024 In UP, each well-formed byte with bit7=0 SHALL update lane and proj_type, pulse pkt_strobe, and pulse fire_pulse iff bit5=1 and prev_fire=0; prev_fire SHALL then take bit5.
REQ-025 In UP, a well-formed byte with bit7=1 SHALL force lane=3 and proj_type=0, set prev_fire=1 (no fire pulse on release), and pulse pkt_strobe.
REQ-026 For bit7=1 bytes, remote_rst_pulse SHALL pulse only on the first such byte after a byte with bit7=0 or after link acquisition (edge-detected).
REQ-027 The timer SHALL clear on each well-formed byte and increment otherwise, with width clog2(TIMEOUT_CYCLES+1) bits, and SHALL saturate.
REQ-028 A timeout SHALL occur when the timer equals TIMEOUT_CYCLES.
REQ-029 If a well-formed byte arrives in the same cycle the timer reaches TIMEOUT_CYCLES, the byte SHALL win: no timeout, timer cleared.
REQ-030 Outside UP, the outputs SHALL hold lane=3, proj_type=0 and link_up=0, with fire_pulse, pkt_strobe and remote_rst_pulse held at 0.
REQ-031 On UP->DOWN, lane SHALL return to 3 and proj_type to 0 on the next cycle; err_count SHALL be retained.

Reset
REQ-032 While rst=1 at a clk edge, the block SHALL enter DOWN with lane=3, proj_type=0, all pulses=0, link_up=0, err_count=0, timer=0, acq_cnt=0 and prev_fire=0.
REQ-033 rst SHALL take priority over a simultaneous rx_valid, and a byte presented in that cycle SHALL be discarded.
REQ-034 A reset asserted mid-acquisition or while UP SHALL require a full reacquisition of ACQ_PKTS packets.

Verification
REQ-035 The bench SHALL cover: after reset, bytes 0x03 then 0x04 -> link_up=1 one cycle after the second byte, lane=4, no fire_pulse or pkt_strobe.
REQ-036 The bench SHALL cover: while UP, bytes 0x05, 0x25, 0x25, 0x05, 0x25 -> exactly two fire_pulses, lane=5, five pkt_strobes.
REQ-037 The bench SHALL cover: while UP, bytes 0x47 then 0x4A -> both dropped, err_count=2, lane unchanged; 300 malformed bytes -> err_count=255.
REQ-038 The bench SHALL cover: while UP, bytes 0x82, 0x82, 0x00 -> one remote_rst_pulse, lane=3, proj_type=0, no fire_pulse.
REQ-039 The bench SHALL cover, with TIMEOUT_CYCLES=100: no bytes for 100 cycles -> link_up=0 and lane=3; a well-formed byte exactly on cycle 100 -> link stays up.
REQ-040 The bench SHALL cover: rst asserted in the same cycle as rx_valid with 0x13 -> state DOWN, byte ignored, all outputs at reset values.
